// File: rtl/seg_scan_driver.sv
// Double-buffered multiplexed driver for an 8-digit 7-segment array with a valid/ready frame load.
// Optional macro SEG_SCAN_BRIGHT_EN adds a 3-bit per-slot brightness (PWM) input.
module seg_scan_driver #(
    parameter int unsigned NUM_DIG = 8,
    parameter int unsigned DIV     = 5000,
    parameter int unsigned BLANK   = 250
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_DIG-1:0]   seg_in,
    input  logic                   load_valid,
    output logic                   load_ready,
`ifdef SEG_SCAN_BRIGHT_EN
    input  logic [2:0]             bright,
`endif
    output logic [7:0]             seg_data,
    output logic [NUM_DIG-1:0]     seg_com,
    output logic                   frame_done
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [8*NUM_DIG-1:0] active;
    logic [8*NUM_DIG-1:0] shadow;
    logic                 pending;

    logic                 slot_end;
    logic                 frame_end;
    logic                 load_acc;
    logic                 lit;
    logic [7:0]           data_nxt;
    logic [NUM_DIG-1:0]   com_nxt;

`ifdef SEG_SCAN_BRIGHT_EN
    logic [2:0]           bright_q;
    logic [2:0]           bright_eff;
    logic [2:0]           pwm_ph;
`endif

    assign load_ready = !pending;

    always_comb begin
        slot_end  = (cnt == CW'(DIV - 1));
        frame_end = slot_end && (idx == IW'(NUM_DIG - 1));
        load_acc  = load_valid && !pending;
        lit       = (cnt >= CW'(BLANK));
`ifdef SEG_SCAN_BRIGHT_EN
        // bright is captured at cnt == 0, so the first cycle of a slot uses the live input
        bright_eff = (cnt == '0) ? bright : bright_q;
        pwm_ph     = 3'({3'b000, cnt} - (CW + 3)'(BLANK));
        if (pwm_ph > bright_eff) begin
            lit = 1'b0;
        end
`endif
        com_nxt  = '1;
        data_nxt = '0;
        if (lit) begin
            com_nxt  = ~(NUM_DIG'(1) << idx);
            data_nxt = active[{idx, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            seg_data   <= '0;
            seg_com    <= '1;
            frame_done <= 1'b0;
`ifdef SEG_SCAN_BRIGHT_EN
            bright_q   <= 3'd7;
`endif
        end else begin
            seg_data   <= data_nxt;
            seg_com    <= com_nxt;
            frame_done <= frame_end;

            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IW'(NUM_DIG - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

`ifdef SEG_SCAN_BRIGHT_EN
            if (cnt == '0) begin
                bright_q <= bright;
            end
`endif

            // swap needs pending=1 and a load needs pending=0, so they never collide
            if (frame_end && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (load_acc) begin
                shadow  <= seg_in;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: frame-level model plus directed literal checks.
module tb_seg_scan_driver;

    localparam int NUM_DIG = 8;
`ifdef SEG_SCAN_BRIGHT_EN
    localparam int DIV = 17;
`else
    localparam int DIV = 4;
`endif
    localparam int BLANK = 1;
    localparam int FRAME = NUM_DIG * DIV;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [8*NUM_DIG-1:0] seg_in = '0;
    logic                 load_valid = 1'b0;
    logic                 load_ready;
    logic [7:0]           seg_data;
    logic [NUM_DIG-1:0]   seg_com;
    logic                 frame_done;
`ifdef SEG_SCAN_BRIGHT_EN
    logic [2:0]           bright = 3'd3;
`endif

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    seg_scan_driver #(
        .NUM_DIG (NUM_DIG),
        .DIV     (DIV),
        .BLANK   (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
`ifdef SEG_SCAN_BRIGHT_EN
        .bright     (bright),
`endif
        .seg_data   (seg_data),
        .seg_com    (seg_com),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
        end
    endfunction

    // Model: display position is the cycle count since reset modulo the frame length
    int                 m_cyc = 0;
    logic [7:0]         m_active [NUM_DIG];
    logic [7:0]         m_shadow [NUM_DIG];
    bit                 m_pending = 1'b0;
    int                 m_bright = 7;
    logic [7:0]         exp_data = '0;
    logic [NUM_DIG-1:0] exp_com = '1;
    bit                 exp_fd = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0;
            m_pending = 1'b0;
            exp_data = '0;
            exp_com = '1;
            exp_fd = 1'b0;
            for (int d = 0; d < NUM_DIG; d++) begin
                m_active[d] = '0;
                m_shadow[d] = '0;
            end
        end else begin
            int p, dig, ph;
            bit on, boundary;
            p = m_cyc % FRAME;
            dig = p / DIV;
            ph = p % DIV;
            on = (ph >= BLANK);
`ifdef SEG_SCAN_BRIGHT_EN
            if (ph == 0) m_bright = int'(bright);
            if (on && ((ph - BLANK) % 8) > m_bright) on = 1'b0;
`endif
            exp_com = on ? ~(NUM_DIG'(1) << dig) : '1;
            exp_data = on ? m_active[dig] : 8'h00;
            boundary = (p == FRAME - 1);
            exp_fd = boundary;
            if (boundary && m_pending) begin
                for (int d = 0; d < NUM_DIG; d++) m_active[d] = m_shadow[d];
                m_pending = 1'b0;
            end else if (load_valid && !m_pending) begin
                for (int d = 0; d < NUM_DIG; d++) m_shadow[d] = seg_in[8*d +: 8];
                m_pending = 1'b1;
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("seg_data", 32'(seg_data), 32'(exp_data));
            check("seg_com", 32'(seg_com), 32'(exp_com));
            check("frame_done", 32'(frame_done), 32'(exp_fd));
            check("load_ready", 32'(load_ready), 32'(!m_pending));
        end
    end

    function automatic int P(input int f, input int d, input int ph);
        return f * FRAME + d * DIV + ph;
    endfunction

    task automatic wait_cyc(input int t);
        while (m_cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_at(input int t, input logic [7:0] base, input logic [7:0] step);
        wait_cyc(t);
        #1;
        for (int d = 0; d < NUM_DIG; d++) seg_in[8*d +: 8] = 8'(base + step * 8'(d));
        load_valid = 1'b1;
    endtask

    task automatic drop_at(input int t);
        wait_cyc(t);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic check_at(input int pos, input string name, input logic [7:0] ecom, input logic [7:0] edat);
        wait_cyc(pos + 1);
        @(negedge clk);
        check({name, "_com"}, 32'(seg_com), 32'(ecom));
        check({name, "_dat"}, 32'(seg_data), 32'(edat));
    endtask

    task automatic check_ctl(input int cyc, input string name, input bit efd, input bit erdy);
        wait_cyc(cyc);
        @(negedge clk);
        check({name, "_fd"}, 32'(frame_done), 32'(efd));
        check({name, "_rdy"}, 32'(load_ready), 32'(erdy));
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_com"}, 32'(seg_com), 32'hFF);
        check({name, "_dat"}, 32'(seg_data), 32'h00);
        check({name, "_rdy"}, 32'(load_ready), 32'h1);
        check({name, "_fd"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        check_reset_vals("por");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // frame A: digit i = 8'h11*i
        load_at(2, 8'h00, 8'h11);
        drop_at(3);
        check_ctl(3, "a_busy", 1'b0, 1'b0);
        check_at(P(0, 3, 2), "f0_d3", 8'hF7, 8'h00);
        check_ctl(FRAME, "a_swap", 1'b1, 1'b1);
        check_at(P(1, 0, 0), "f1_blank", 8'hFF, 8'h00);
        check_at(P(1, 0, 1), "f1_d0", 8'hFE, 8'h00);
        check_at(P(1, 2, 3), "f1_d2", 8'hFB, 8'h22);

        // back-pressure: X accepted, Y held while pending is ignored
        load_at(P(1, 3, 0), 8'hA0, 8'h01);
        drop_at(P(1, 3, 0) + 1);
        load_at(P(1, 3, 3), 8'h50, 8'h01);
        check_ctl(P(1, 3, 3) + 1, "y_block", 1'b0, 1'b0);
        drop_at(P(1, 6, 0));
        check_at(P(1, 7, 1), "f1_d7", 8'h7F, 8'h77);
        check_ctl(2 * FRAME, "x_swap", 1'b1, 1'b1);

        // tearing: T loaded mid-frame must not appear until the next frame
        load_at(P(2, 2, 0), 8'hC0, 8'h01);
        drop_at(P(2, 2, 0) + 1);
        check_at(P(2, 4, 2), "f2_d4", 8'hEF, 8'hA4);
        check_at(P(2, 6, 3), "f2_d6", 8'hBF, 8'hA6);
        check_at(P(3, 1, 1), "f3_d1", 8'hFD, 8'hC1);

        // Z accepted on the boundary cycle, shown one frame later; W blocked across the swap
        load_at(4 * FRAME - 1, 8'hE0, 8'h01);
        drop_at(4 * FRAME);
        check_at(P(4, 5, 1), "f4_d5", 8'hDF, 8'hC5);
        load_at(P(4, 6, 0), 8'h90, 8'h01);
        drop_at(P(5, 0, 0));
        check_at(P(5, 0, 1), "f5_d0", 8'hFE, 8'hE0);
        check_at(P(5, 3, 2), "f5_d3", 8'hF7, 8'hE3);
`ifdef SEG_SCAN_BRIGHT_EN
        check_at(P(5, 4, 6), "f5_d4_dim", 8'hFF, 8'h00);
`endif

        // reset mid digit 5 with V pending: V must be discarded
        load_at(P(6, 2, 0), 8'h70, 8'h01);
        drop_at(P(6, 2, 0) + 1);
        check_ctl(P(6, 2, 0) + 1, "v_busy", 1'b0, 1'b0);
        wait_cyc(P(6, 5, 2));
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        check_at(P(0, 7, 2), "r0_d7", 8'h7F, 8'h00);
        check_at(P(1, 3, 2), "r1_d3", 8'hF7, 8'h00);
        wait_cyc(P(2, 0, 0));
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
